mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction accesses. It accepts one load or store request at a time over a valid/ready handshake, performs byte/halfword/word accesses on an internal word-organised RAM (read-modify-write for sub-word stores), and returns data or an error over a second valid/ready handshake. It replaces the fixed-latency memory model so the control unit can tolerate variable access time and misaligned-access exceptions.

---
 rtl/mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle CPU. Accepts one load/store at a
// time over a valid/ready request channel, accesses an internal word-organised
// RAM (read-modify-write for byte/halfword stores) and returns load data or a
// fault indication over a valid/ready response channel.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    responder idle and able to accept a request
//   req_write_i    1 = store, 0 = load
//   req_size_i     00 word, 01 halfword, 10 byte, 11 illegal
//   req_addr_i     byte address (bits above ADDR_W+1 ignored, wrap-around)
//   req_wdata_i    store data, right-aligned
//   resp_valid_o   response present
//   resp_ready_i   requester accepts the response
//   resp_rdata_o   load data, zero-extended and right-aligned; 0 otherwise
//   resp_err_o     misaligned access or illegal size
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BA_W  = ADDR_W + 2;   // byte-address bits that reach the RAM

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              write_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [BA_W-1:0]   addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rword_q;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              req_fault;

    // Upper address bits are deliberately dropped: accesses wrap around.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:BA_W];

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lo);
        logic f;
        f = 1'b0;
        case (size)
            SZ_WORD: f = (lo != 2'b00);
            SZ_HALF: f = lo[0];
            SZ_BYTE: f = 1'b0;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    // Little-endian lane select, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: r = lo[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            SZ_BYTE: begin
                case (lo)
                    2'd0:    r = {24'h000000, word[7:0]};
                    2'd1:    r = {24'h000000, word[15:8]};
                    2'd2:    r = {24'h000000, word[23:16]};
                    default: r = {24'h000000, word[31:24]};
                endcase
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Insert right-aligned store data into the addressed lane(s) of the old word.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: begin
                if (lo[1]) r[31:16] = wdata[15:0];
                else       r[15:0]  = wdata[15:0];
            end
            SZ_BYTE: begin
                case (lo)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    assign req_ready_o = (state_q == ST_IDLE) && rst_ni;
    assign accept      = (state_q == ST_IDLE) && req_valid_i;
    assign req_fault   = access_fault(req_size_i, req_addr_i[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i) state_d = req_fault ? ST_RESP : ST_READ;
            ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write_i;
                err_q   <= req_fault;
            end
        end
    end

    // Request payload; only meaningful while a request is in flight.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            size_q  <= req_size_i;
            addr_q  <= req_addr_i[BA_W-1:0];
            wdata_q <= req_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // RAM: read in READ, write on the edge that ends WRITE
    // -------------------------------------------------------------------------
    // A reset falling during READ/WRITE forces IDLE immediately, so the
    // pending store never reaches the RAM.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_READ)
            rword_q <= mem_q[addr_q[BA_W-1:2]];
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_WRITE)
            mem_q[addr_q[BA_W-1:2]] <= lane_merge(rword_q, wdata_q, size_q, addr_q[1:0]);
    end

    // -------------------------------------------------------------------------
    // Response outputs, all derived from registered state only
    // -------------------------------------------------------------------------
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_err_o   = resp_valid_o && err_q;
    assign resp_rdata_o = (resp_valid_o && !err_q && !write_q)
                        ? lane_extract(rword_q, size_q, addr_q[1:0])
                        : 32'h0000_0000;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int MB     = 4 << ADDR_W;   // bytes in the modelled RAM

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain byte-addressed memory.
    logic [7:0] mbytes [MB];

    mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            r[8*i +: 8] = mbytes[(int'(a % MB) + i) % MB];
        return r;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++)
            mbytes[(int'(a % MB) + i) % MB] = wd[8*i +: 8];
    endtask

    // One complete transaction. Called at a point away from the rising edge
    // with the responder expected idle; returns just after the negedge that
    // follows the response handshake, so a back-to-back call tests the
    // earliest possible next accept.
    task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_d;
        int          lat;
        exp_err = model_err(sz, a);
        exp_lat = exp_err ? 1 : (w ? 3 : 2);
        exp_d   = (exp_err || w) ? 32'h0 : model_load(sz, a);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!exp_err && w) model_store(sz, a, wd);
        lat = 1;
        forever begin
            @(negedge clk);
            if (resp_valid || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_rdata", resp_rdata, exp_d);
        got = resp_rdata;

        // Backpressure: response must stay put; stray requests must be ignored.
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 2 == 0);
            req_write = 1'b1;
            req_size  = 2'd0;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_d);
            check("hold_err", 32'(resp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("resp_dropped", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic        w;
        logic [1:0]  sz;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Word store then load.
        xact(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 0, got);
        check("st_word_rdata", got, 32'h0);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_word_10", got, 32'hDEADBEEF);

        // Byte store and sub-word loads.
        xact(1'b1, 2'd2, 32'h11, 32'h000000AA, 0, got);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_after_byte", got, 32'hDEADAAEF);
        xact(1'b0, 2'd2, 32'h13, 32'h0, 0, got);
        check("ld_byte_13", got, 32'h000000DE);
        xact(1'b0, 2'd1, 32'h12, 32'h0, 0, got);
        check("ld_half_12", got, 32'h0000DEAD);

        // Halfword store.
        xact(1'b1, 2'd1, 32'h12, 32'h00001234, 0, got);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_after_half", got, 32'h1234AAEF);
        xact(1'b0, 2'd1, 32'h10, 32'h0, 0, got);
        check("ld_half_10", got, 32'h0000AAEF);

        // Faults: misaligned word store must not write; misaligned half; size 11.
        xact(1'b1, 2'd0, 32'h11, 32'h00000000, 0, got);
        xact(1'b0, 2'd1, 32'h13, 32'h0, 0, got);
        xact(1'b0, 2'd3, 32'h10, 32'h0, 0, got);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_after_faults", got, 32'h1234AAEF);

        // Backpressure with stray request pulses.
        xact(1'b0, 2'd0, 32'h10, 32'h0, 5, got);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_after_backpressure", got, 32'h1234AAEF);

        // Reset in the middle of a store's WRITE cycle.
        xact(1'b1, 2'd0, 32'h20, 32'h11111111, 0, got);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h20;
        req_wdata = 32'h55555555;
        @(posedge clk);          // accept -> READ
        #1;
        req_valid = 1'b0;
        @(posedge clk);          // READ -> WRITE
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_req_ready", 32'(req_ready), 32'd0);
        check("rstw_resp_valid", 32'(resp_valid), 32'd0);
        check("rstw_resp_err", 32'(resp_err), 32'd0);
        check("rstw_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstw_ready_after", 32'(req_ready), 32'd1);
        xact(1'b0, 2'd0, 32'h20, 32'h0, 0, got);
        check("ld_20_after_rst", got, 32'h11111111);

        // Address wrap-around aliasing.
        xact(1'b1, 2'd0, 32'h10 + (32'd1 << (ADDR_W + 2)), 32'hCAFEF00D, 0, got);
        xact(1'b0, 2'd0, 32'h10, 32'h0, 0, got);
        check("ld_alias", got, 32'hCAFEF00D);

        // Randomised phase: fill a window with known data, then mix accesses.
        for (int i = 0; i < 16; i++) begin
            a = (32'(i) * 4) | (32'($urandom_range(0, 7)) << (ADDR_W + 2));
            xact(1'b1, 2'd0, a, $urandom, 0, got);
        end
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << (ADDR_W + 2));
            xact(w, sz, a, $urandom, $urandom_range(0, 2), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
